// File: rtl/crypto_lane_responder.sv
// Lane-side stub for the crypto unit: three preloaded operand FIFOs feeding the unit,
// plus a VRF write responder that grants result writes after a fixed latency.
module crypto_lane_responder #(
   parameter int ELEN       = 64,
   parameter int AddrW      = 32,
   parameter int IdW        = 3,
   parameter int OpDepth    = 8,
   parameter int GntLatency = 2,
   parameter int CntW       = 16
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   input  logic [IdW-1:0]        cfg_id_i,
   input  logic [CntW-1:0]       cfg_nelem_i,
   input  logic [2:0]            op_push_i,
   input  logic [3*ELEN-1:0]     op_data_i,
   output logic [2:0]            op_full_o,
   output logic [3*ELEN-1:0]     crypto_operand_o,
   output logic [2:0]            crypto_operand_valid_o,
   input  logic [2:0]            crypto_operand_ready_i,
   input  logic                  crypto_result_req_i,
   input  logic [IdW-1:0]        crypto_result_id_i,
   input  logic [AddrW-1:0]      crypto_result_addr_i,
   input  logic [ELEN-1:0]       crypto_result_wdata_i,
   input  logic [ELEN/8-1:0]     crypto_result_be_i,
   output logic                  crypto_result_gnt_o,
   output logic                  crypto_result_final_gnt_o,
   output logic                  wr_valid_o,
   output logic [AddrW-1:0]      wr_addr_o,
   output logic [ELEN-1:0]       wr_data_o,
   output logic [ELEN/8-1:0]     wr_be_o,
   output logic                  done_o,
   output logic [2:0]            err_o
);

   localparam int PtrW = (OpDepth > 1) ? $clog2(OpDepth) : 1;
   localparam int BeW  = ELEN / 8;
   localparam logic [3:0] GntLat = 4'(GntLatency);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_REQ = 3'd1,
      S_DELAY    = 3'd2,
      S_GRANT    = 3'd3,
      S_COMMIT   = 3'd4
   } state_e;

   logic [2:0] ovf_s;

   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_fifo
      logic [ELEN-1:0] mem_q [OpDepth];
      logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [PtrW:0]   count_q, count_d;
      logic            full_s, empty_s, push_s, pop_s;

      // Full is judged on the pre-pop count, so a push into a full FIFO is lost even with a pop.
      always_comb begin
         full_s   = (count_q == (PtrW+1)'(OpDepth));
         empty_s  = (count_q == '0);
         push_s   = op_push_i[gi] & ~full_s;
         pop_s    = crypto_operand_ready_i[gi] & ~empty_s;
         wr_ptr_d = push_s ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
         rd_ptr_d = pop_s ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
         endcase
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      always_ff @(posedge clk_i) begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= op_data_i[gi*ELEN +: ELEN];
         end
      end

      assign op_full_o[gi]                     = full_s;
      assign crypto_operand_valid_o[gi]        = ~empty_s;
      assign crypto_operand_o[gi*ELEN +: ELEN] = empty_s ? '0 : mem_q[rd_ptr_q];
      assign ovf_s[gi]                         = op_push_i[gi] & full_s;
   end

   state_e           state_q, state_d;
   logic [IdW-1:0]   cfg_id_q, cfg_id_d;
   logic [CntW-1:0]  nelem_q, nelem_d, cnt_q, cnt_d;
   logic [3:0]       wait_q, wait_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [ELEN-1:0]  data_q, data_d;
   logic [BeW-1:0]   be_q, be_d;
   logic [2:0]       err_q, err_d;
   logic             done_zero_q, done_zero_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cfg_id_q    <= '0;
         nelem_q     <= '0;
         cnt_q       <= '0;
         wait_q      <= 4'd0;
         addr_q      <= '0;
         data_q      <= '0;
         be_q        <= '0;
         err_q       <= 3'b000;
         done_zero_q <= 1'b0;
      end else begin
         cfg_id_q    <= cfg_id_d;
         nelem_q     <= nelem_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         be_q        <= be_d;
         err_q       <= err_d;
         done_zero_q <= done_zero_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cfg_id_d    = cfg_id_q;
      nelem_d     = nelem_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      data_d      = data_q;
      be_d        = be_q;
      err_d       = err_q | {(|ovf_s), 2'b00};
      done_zero_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_valid_i && (cfg_nelem_i != '0)) begin
               cfg_id_d = cfg_id_i;
               nelem_d  = cfg_nelem_i;
               cnt_d    = '0;
               state_d  = S_WAIT_REQ;
            end else begin
               done_zero_d = cfg_valid_i;
            end
         end
         S_WAIT_REQ: begin
            if (crypto_result_req_i) begin
               addr_d   = crypto_result_addr_i;
               data_d   = crypto_result_wdata_i;
               be_d     = crypto_result_be_i;
               wait_d   = 4'd0;
               err_d[0] = err_d[0] | (crypto_result_id_i != cfg_id_q);
               state_d  = (GntLat == 4'd0) ? S_GRANT : S_DELAY;
            end else begin
               state_d = S_WAIT_REQ;
            end
         end
         S_DELAY: begin
            if (!crypto_result_req_i) begin
               err_d[1] = 1'b1;
               state_d  = S_WAIT_REQ;
            end else if (wait_q == (GntLat - 4'd1)) begin
               state_d = S_GRANT;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_GRANT: begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            state_d = (cnt_q == nelem_q) ? S_IDLE : S_WAIT_REQ;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes decode straight from the state register, so they drop the instant reset hits.
   always_comb begin
      cfg_ready_o               = 1'b0;
      crypto_result_gnt_o       = 1'b0;
      crypto_result_final_gnt_o = 1'b0;
      wr_valid_o                = 1'b0;
      done_o                    = done_zero_q;
      case (state_q)
         S_IDLE:   cfg_ready_o = 1'b1;
         S_GRANT:  crypto_result_gnt_o = 1'b1;
         S_COMMIT: begin
            crypto_result_final_gnt_o = 1'b1;
            wr_valid_o                = 1'b1;
            done_o                    = done_zero_q | (cnt_q == nelem_q);
         end
         default:  cfg_ready_o = 1'b0;
      endcase
   end

   assign wr_addr_o = addr_q;
   assign wr_data_o = data_q;
   assign wr_be_o   = be_q;
   assign err_o     = err_q;

endmodule

// File: doc/crypto_lane_responder.md
Name: crypto_lane_responder

Overview:
Lane-side counterpart of the crypto unit's lane interface, instantiated once per lane in the crypto_unit testbench and usable as a lane stub in subsystem sims. It sources the three operand streams {vs1, vd, vs2} into the crypto unit from preloaded FIFOs. It also acts as the VRF write responder: it grants result requests after a programmable latency, pulses final_gnt, and exports every committed write for the scoreboard.

Parameters:
ELEN, 64, operand/result data width
AddrW, 32, result address width (vaddr_t)
IdW, 3, instruction id width (clog2 NrVInsn)
OpDepth, 8, per-operand FIFO depth, power of two, >=2
GntLatency, 2, extra wait cycles between request sampling and grant (0..15)
CntW, 16, element counter width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_valid_i  in  1  start a result transaction
cfg_ready_o  out  1  responder idle, can accept cfg
cfg_id_i  in  IdW  expected result id
cfg_nelem_i  in  CntW  number of result writes to grant
op_push_i  in  3  per-operand FIFO push, bit order {vs1,vd,vs2}
op_data_i  in  3*ELEN  push data
op_full_o  out  3  FIFO full
crypto_operand_o  out  3*ELEN  FIFO heads
crypto_operand_valid_o  out  3  FIFO non-empty
crypto_operand_ready_i  in  3  pop
crypto_result_req_i  in  1  write request
crypto_result_id_i  in  IdW  request id
crypto_result_addr_i  in  AddrW  request address
crypto_result_wdata_i  in  ELEN  request data
crypto_result_be_i  in  ELEN/8  byte enables
crypto_result_gnt_o  out  1  grant pulse
crypto_result_final_gnt_o  out  1  commit pulse
wr_valid_o  out  1  committed write strobe
wr_addr_o  out  AddrW  committed address
wr_data_o  out  ELEN  committed data
wr_be_o  out  ELEN/8  committed byte enables
done_o  out  1  transaction complete pulse
err_o  out  3  sticky {overflow, req_drop, id_mismatch}

Behaviour:
- Reset, asynchronous: FSM=IDLE, FIFOs empty, counters 0.
  - Outputs after reset: cfg_ready_o=1; all valid/gnt/final_gnt/wr_valid/done=0; op_full_o=0; err_o=0; data outputs=0.
- Operand FIFOs, three independent instances:
  - Push when !full writes tail; head is visible the cycle after the push (registered, no fall-through).
  - Pop occurs on valid&&ready.
  - Full is evaluated before the pop, so push while full is dropped even if a pop happens in the same cycle, and sets err_o[2].
  - Simultaneous push+pop when neither empty nor full: count is unchanged.
  - Pointers wrap modulo OpDepth.
- FSM states: IDLE, WAIT_REQ, DELAY, GRANT, COMMIT.
  - IDLE: cfg_ready_o=1.
    - cfg_valid_i with nelem>0: latch id/nelem, cnt=0, go to WAIT_REQ.
    - cfg_valid_i with nelem=0: done_o pulses next cycle, stay IDLE.
  - WAIT_REQ: req_i high in cycle t latches id/addr/wdata/be.
    - Go to DELAY (GntLatency>0) or GRANT (GntLatency=0).
    - Latched id != cfg id sets err_o[0]; the write is still granted.
  - DELAY: wait counter runs GntLatency cycles.
    - req_i low in any DELAY cycle sets err_o[1] and returns to WAIT_REQ; no grant is issued.
  - GRANT: crypto_result_gnt_o=1 for exactly one cycle, at t+1+GntLatency. cnt++, go to COMMIT.
  - COMMIT, one cycle: crypto_result_final_gnt_o=1 and wr_valid_o=1 with the latched addr/data/be.
    - If cnt==nelem: done_o=1 in the same cycle, go to IDLE.
    - Otherwise go to WAIT_REQ.
    - A req_i seen in COMMIT is not sampled; it is sampled next cycle in WAIT_REQ.
- Minimum spacing between grants is 3+GntLatency cycles.
- cfg_valid_i outside IDLE is ignored; cfg_ready_o=0 in all non-IDLE states.
- err_o bits are sticky until reset.
- Reset mid-transaction aborts immediately: no gnt/final_gnt after rstn_i deasserts, and FIFO contents are lost.
- Operand path and result FSM are fully independent and may run concurrently.

Test Plan:
- Reset then idle: all outputs zero, cfg_ready_o=1, op_full_o=000.
- GntLatency=2, cfg nelem=3 id=5, req held with id=5, addr 0x40/0x48/0x50 -> each gnt 3 cycles after req sampled, final_gnt+wr_valid next cycle with matching addr/data/be, done_o with the third commit, err_o=000.
- Push 8 words into vs2 FIFO (OpDepth=8) with ready low -> op_full_o[0]=1. Ninth push, concurrent with a pop -> dropped, err_o[2]=1. Pops return 8 words in order.
- Drop req_i during DELAY -> no gnt, err_o[1]=1. Re-raised req granted normally.
- Request id=2 against cfg id=5 -> granted and committed, err_o[0]=1.
- cfg nelem=0 -> done_o pulse next cycle, no gnt. Async reset asserted in GRANT state -> gnt/final_gnt low immediately, FSM IDLE.
